// File: rtl/code_word_packer.sv
// code_word_packer: packs right-aligned variable-length codewords (0..32 bits)
// MSB-first into a 64-bit left-aligned accumulator and emits 32-bit words with
// valid/ready flow control. A flush drains the tail as a zero-padded final word.
//
// Ports:
//   clk, reset (async, active-low)
//   code_valid/code_data/code_len/code_ready : codeword input handshake
//   flush_req                                : pulse to close the stream
//   out_valid/out_data/out_len/out_last/out_ready : packed word output handshake
//   flush_done                               : one-cycle pulse when flush completes
//   total_bits                               : running count of emitted valid bits
module code_word_packer #(
  parameter int unsigned CODE_W = 32,
  parameter int unsigned LEN_W  = 6,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code_data,
  input  logic [LEN_W-1:0]  code_len,
  output logic              code_ready,
  input  logic              flush_req,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_last,
  input  logic              out_ready,
  output logic              flush_done,
  output logic [CNT_W-1:0]  total_bits
);

  localparam int unsigned ACC_W  = 2 * OUT_W;
  localparam int unsigned FILL_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic               live_q;

  logic [ACC_W-1:0]   acc_e;
  logic [FILL_W-1:0]  fill_e;
  logic [FILL_W-1:0]  shamt;
  logic [CODE_W-1:0]  code_mask;
  logic [ACC_W-1:0]   code_ext;

  // Strip don't-care bits above code_len and widen to accumulator width.
  always_comb begin
    code_mask = '0;
    if (code_len != '0) begin
      code_mask = {CODE_W{1'b1}} >> (LEN_W'(CODE_W) - code_len);
    end
    code_ext = ACC_W'(code_data & code_mask);
  end

  // State, accumulator, fill and bit counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      total_q <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      total_q <= total_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state, datapath and handshake outputs.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    fill_d     = fill_q;
    total_d    = total_q;
    acc_e      = acc_q;
    fill_e     = fill_q;
    shamt      = '0;
    code_ready = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_len    = '0;
    out_last   = 1'b0;
    flush_done = 1'b0;

    case (state_q)
      ST_RUN: begin
        // live_q keeps code_ready low while reset is asserted.
        code_ready = live_q && (fill_q <= FILL_W'(OUT_W));
        if (fill_q >= FILL_W'(OUT_W)) begin
          out_valid = 1'b1;
          out_data  = acc_q[ACC_W-1 -: OUT_W];
          out_len   = LEN_W'(OUT_W);
        end
        if (out_valid && out_ready) begin
          acc_e  = acc_q << OUT_W;
          fill_e = fill_q - FILL_W'(OUT_W);
        end
        acc_d  = acc_e;
        fill_d = fill_e;
        // New code lands directly below the bits still held after any emit.
        if (code_valid && code_ready) begin
          shamt  = FILL_W'(ACC_W) - fill_e - FILL_W'(code_len);
          acc_d  = acc_e | (code_ext << shamt);
          fill_d = fill_e + FILL_W'(code_len);
        end
        if (flush_req) begin
          state_d = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (fill_q == '0) begin
          state_d = ST_DONE;
        end else if (fill_q >= FILL_W'(OUT_W)) begin
          out_valid = 1'b1;
          out_data  = acc_q[ACC_W-1 -: OUT_W];
          out_len   = LEN_W'(OUT_W);
          out_last  = (fill_q == FILL_W'(OUT_W));
          if (out_ready) begin
            acc_d  = acc_q << OUT_W;
            fill_d = fill_q - FILL_W'(OUT_W);
            if (out_last) begin
              state_d = ST_DONE;
            end
          end
        end else begin
          // Partial tail word: zero everything below the valid region.
          out_valid = 1'b1;
          out_data  = acc_q[ACC_W-1 -: OUT_W] & ~({OUT_W{1'b1}} >> fill_q);
          out_len   = LEN_W'(fill_q);
          out_last  = 1'b1;
          if (out_ready) begin
            acc_d   = '0;
            fill_d  = '0;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        flush_done = 1'b1;
        acc_d      = '0;
        fill_d     = '0;
        state_d    = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (out_valid && out_ready) begin
      total_d = total_q + CNT_W'(out_len);
    end
  end

  assign total_bits = total_q;

endmodule
